// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the ID->EX boundary: decodes the immediate,
// precomputes pc + imm, and decouples both sides with a one-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [2:0]      imm_sel_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int SHAMT_W = (XLEN == 32) ? 5 : 6;

    localparam logic [2:0] SEL_R       = 3'd0;
    localparam logic [2:0] SEL_I       = 3'd1;
    localparam logic [2:0] SEL_I_SHIFT = 3'd2;
    localparam logic [2:0] SEL_S       = 3'd3;
    localparam logic [2:0] SEL_B       = 3'd4;
    localparam logic [2:0] SEL_U       = 3'd5;
    localparam logic [2:0] SEL_J       = 3'd6;
    localparam logic [2:0] SEL_Z       = 3'd7;

    // Bit 1 is the ready flag and bit 0 the main-valid flag, so both handshake
    // outputs come straight from state flops with no decode logic.
    typedef enum logic [1:0] {
        EMPTY = 2'b10,
        FULL  = 2'b11,
        SKID  = 2'b01
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            in_xfer;
    logic            out_xfer;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    logic [XLEN-1:0] new_imm;
    logic [XLEN-1:0] new_target;
    logic [XLEN-1:0] main_imm;
    logic [XLEN-1:0] main_target;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] skid_imm;
    logic [XLEN-1:0] skid_target;
    logic [XLEN-1:0] skid_pc;
    logic            unused_opcode;

    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        new_imm = '0;
        case (imm_sel_i)
            SEL_R:       new_imm = '0;
            SEL_I:       new_imm = XLEN'($signed(inst_i[31:20]));
            SEL_I_SHIFT: new_imm = XLEN'(inst_i[20 +: SHAMT_W]);
            SEL_S:       new_imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            SEL_B:       new_imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                                  inst_i[11:8], 1'b0}));
            SEL_U:       new_imm = XLEN'($signed({inst_i[31:12], 12'b0}));
            SEL_J:       new_imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                                  inst_i[30:21], 1'b0}));
            SEL_Z:       new_imm = XLEN'(inst_i[19:15]);
            default:     new_imm = '0;
        endcase
    end

    assign new_target = pc_i + new_imm;

    assign in_ready_o  = state_q[1];
    assign out_valid_o = state_q[0];
    assign in_xfer     = in_valid_i & state_q[1];
    assign out_xfer    = state_q[0] & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main_in = 1'b1;
                        state_d      = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = SKID;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        load_main_skid = 1'b1;
                        state_d        = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Payload registers only move on a load, so outputs hold while stalled or idle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= EMPTY;
            main_imm    <= '0;
            main_target <= '0;
            main_pc     <= '0;
            skid_imm    <= '0;
            skid_target <= '0;
            skid_pc     <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_imm    <= new_imm;
                main_target <= new_target;
                main_pc     <= pc_i;
            end else if (load_main_skid) begin
                main_imm    <= skid_imm;
                main_target <= skid_target;
                main_pc     <= skid_pc;
            end
            if (load_skid) begin
                skid_imm    <= new_imm;
                skid_target <= new_target;
                skid_pc     <= pc_i;
            end
        end
    end

    assign imm_o    = main_imm;
    assign target_o = main_target;
    assign pc_o     = main_pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench driving an XLEN=64 and an XLEN=32 instance in lockstep with
// hand-computed immediates, targets and handshake expectations.
module tb_imm_gen_pipe;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] inst_i;
    logic [2:0]  imm_sel_i;
    logic [63:0] pc_i;
    logic        out_ready_i;

    logic        in_ready64, out_valid64;
    logic [63:0] imm64, target64, pc64;
    logic        in_ready32, out_valid32;
    logic [31:0] imm32, target32, pc32;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready64),
        .inst_i(inst_i), .imm_sel_i(imm_sel_i), .pc_i(pc_i),
        .out_valid_o(out_valid64), .out_ready_i(out_ready_i),
        .imm_o(imm64), .target_o(target64), .pc_o(pc64)
    );

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready32),
        .inst_i(inst_i), .imm_sel_i(imm_sel_i), .pc_i(pc_i[31:0]),
        .out_valid_o(out_valid32), .out_ready_i(out_ready_i),
        .imm_o(imm32), .target_o(target32), .pc_o(pc32)
    );

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [31:0] imm32;
        logic [31:0] tgt32;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [2:0] sel, input logic [31:0] inst, input logic [63:0] pc);
        in_valid_i = 1'b1;
        imm_sel_i  = sel;
        inst_i     = inst;
        pc_i       = pc;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        vectors++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0) begin miscompares++; $display("FAIL reset_valid actual=%b/%b expected=0/0", out_valid64, out_valid32); end
        vectors++; if (imm64 !== 64'd0 || target64 !== 64'd0 || pc64 !== 64'd0) begin miscompares++; $display("FAIL reset_data64 actual=%h/%h/%h expected=0", imm64, target64, pc64); end
        vectors++; if (imm32 !== 32'd0 || target32 !== 32'd0 || pc32 !== 32'd0) begin miscompares++; $display("FAIL reset_data32 actual=%h/%h/%h expected=0", imm32, target32, pc32); end
        rst_n_i = 1'b1;
        tick();
        vectors++; if (in_ready64 !== 1'b1 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0) begin miscompares++; $display("FAIL reset_ready actual=%b/%b valid=%b expected=1/1 valid=0", in_ready64, in_ready32, out_valid64); end
    endtask

    // Back-to-back stream with the sink always ready: each entry appears one edge after acceptance.
    task automatic test_decode();
        vec_t tbl [9];
        tbl[0] = '{3'd1, 32'hFFF00093, 64'h0,         64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[1] = '{3'd4, 32'hFE000EE3, 64'h100,       64'hFFFFFFFFFFFFFFFC, 64'hFC,               32'hFFFFFFFC, 32'hFC};
        tbl[2] = '{3'd6, 32'h0080006F, 64'h200,       64'h8,                64'h208,              32'h8,        32'h208};
        tbl[3] = '{3'd5, 32'h800000B7, 64'h1000,      64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 32'h80000000, 32'h80001000};
        tbl[4] = '{3'd2, 32'h02109093, 64'h0,         64'd33,               64'd33,               32'd1,        32'd1};
        tbl[5] = '{3'd7, 32'h800F8073, 64'h10,        64'h1F,               64'h2F,               32'h1F,       32'h2F};
        tbl[6] = '{3'd0, 32'hFFFFFFFF, 64'h1234,      64'h0,                64'h1234,             32'h0,        32'h1234};
        tbl[7] = '{3'd3, 32'h80000FA3, 64'h800,       64'hFFFFFFFFFFFFF81F, 64'h1F,               32'hFFFFF81F, 32'h1F};
        tbl[8] = '{3'd1, 32'h00100093, 64'h100000000, 64'h1,                64'h100000001,        32'h1,        32'h1};
        out_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            offer(tbl[i].sel, tbl[i].inst, tbl[i].pc);
            tick();
            vectors++; if (out_valid64 !== 1'b1 || out_valid32 !== 1'b1) begin miscompares++; $display("FAIL decode%0d_valid actual=%b/%b expected=1/1", i, out_valid64, out_valid32); end
            vectors++; if (imm64 !== tbl[i].imm64) begin miscompares++; $display("FAIL decode%0d_imm64 actual=%h expected=%h", i, imm64, tbl[i].imm64); end
            vectors++; if (target64 !== tbl[i].tgt64) begin miscompares++; $display("FAIL decode%0d_target64 actual=%h expected=%h", i, target64, tbl[i].tgt64); end
            vectors++; if (pc64 !== tbl[i].pc) begin miscompares++; $display("FAIL decode%0d_pc64 actual=%h expected=%h", i, pc64, tbl[i].pc); end
            vectors++; if (imm32 !== tbl[i].imm32) begin miscompares++; $display("FAIL decode%0d_imm32 actual=%h expected=%h", i, imm32, tbl[i].imm32); end
            vectors++; if (target32 !== tbl[i].tgt32) begin miscompares++; $display("FAIL decode%0d_target32 actual=%h expected=%h", i, target32, tbl[i].tgt32); end
        end
        in_valid_i = 1'b0;
        tick();
        vectors++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0) begin miscompares++; $display("FAIL decode_drain actual=%b/%b expected=0/0", out_valid64, out_valid32); end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        offer(3'd0, 32'h0, 64'hA0);
        tick();
        vectors++; if (out_valid64 !== 1'b1 || pc64 !== 64'hA0 || in_ready64 !== 1'b1) begin miscompares++; $display("FAIL bp_A_main actual=v%b pc%h r%b expected=v1 pcA0 r1", out_valid64, pc64, in_ready64); end
        offer(3'd0, 32'h0, 64'hB0);
        tick();
        vectors++; if (out_valid64 !== 1'b1 || pc64 !== 64'hA0 || in_ready64 !== 1'b0) begin miscompares++; $display("FAIL bp_B_skid actual=v%b pc%h r%b expected=v1 pcA0 r0", out_valid64, pc64, in_ready64); end
        vectors++; if (in_ready32 !== 1'b0 || pc32 !== 32'hA0) begin miscompares++; $display("FAIL bp_B_skid32 actual=r%b pc%h expected=r0 pcA0", in_ready32, pc32); end
        offer(3'd1, 32'h00500093, 64'hC0);
        tick();
        vectors++; if (pc64 !== 64'hA0 || target64 !== 64'hA0 || imm64 !== 64'h0 || in_ready64 !== 1'b0) begin miscompares++; $display("FAIL bp_stall_stable actual=pc%h t%h i%h r%b expected=pcA0 tA0 i0 r0", pc64, target64, imm64, in_ready64); end
        out_ready_i = 1'b1;
        tick();
        vectors++; if (out_valid64 !== 1'b1 || pc64 !== 64'hB0 || in_ready64 !== 1'b1) begin miscompares++; $display("FAIL bp_B_out actual=v%b pc%h r%b expected=v1 pcB0 r1", out_valid64, pc64, in_ready64); end
        tick();
        vectors++; if (out_valid64 !== 1'b1 || pc64 !== 64'hC0 || imm64 !== 64'h5 || target64 !== 64'hC5) begin miscompares++; $display("FAIL bp_C_out actual=v%b pc%h i%h t%h expected=v1 pcC0 i5 tC5", out_valid64, pc64, imm64, target64); end
        vectors++; if (out_valid32 !== 1'b1 || pc32 !== 32'hC0 || target32 !== 32'hC5) begin miscompares++; $display("FAIL bp_C_out32 actual=v%b pc%h t%h expected=v1 pcC0 tC5", out_valid32, pc32, target32); end
        in_valid_i = 1'b0;
        tick();
        vectors++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin miscompares++; $display("FAIL bp_drain actual=v%b r%b expected=v0 r1", out_valid64, in_ready64); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        offer(3'd0, 32'h0, 64'hE0);
        tick();
        offer(3'd0, 32'h0, 64'hF0);
        tick();
        vectors++; if (in_ready64 !== 1'b0 || pc64 !== 64'hE0) begin miscompares++; $display("FAIL flush_fill actual=r%b pc%h expected=r0 pcE0", in_ready64, pc64); end
        offer(3'd0, 32'h0, 64'hD0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        vectors++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0 || in_ready64 !== 1'b1 || in_ready32 !== 1'b1) begin miscompares++; $display("FAIL flush_empty actual=v%b/%b r%b/%b expected=v0/0 r1/1", out_valid64, out_valid32, in_ready64, in_ready32); end
        out_ready_i = 1'b1;
        tick();
        tick();
        vectors++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0) begin miscompares++; $display("FAIL flush_D_dropped actual=v%b/%b pc%h expected=v0/0", out_valid64, out_valid32, pc64); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        offer(3'd1, 32'hFFF00093, 64'h300);
        tick();
        offer(3'd1, 32'hFFF00093, 64'h400);
        tick();
        in_valid_i = 1'b0;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        vectors++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin miscompares++; $display("FAIL rstmid_state actual=v%b/%b r%b/%b expected=v0/0 r1/1", out_valid64, out_valid32, in_ready64, in_ready32); end
        vectors++; if (imm64 !== 64'd0 || target64 !== 64'd0 || pc64 !== 64'd0) begin miscompares++; $display("FAIL rstmid_data64 actual=%h/%h/%h expected=0", imm64, target64, pc64); end
        vectors++; if (imm32 !== 32'd0 || target32 !== 32'd0 || pc32 !== 32'd0) begin miscompares++; $display("FAIL rstmid_data32 actual=%h/%h/%h expected=0", imm32, target32, pc32); end
        out_ready_i = 1'b1;
        tick();
        vectors++; if (out_valid64 !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_ghost actual=v%b expected=v0", out_valid64); end
        offer(3'd6, 32'h0080006F, 64'h500);
        tick();
        in_valid_i = 1'b0;
        vectors++; if (out_valid64 !== 1'b1 || imm64 !== 64'h8 || target64 !== 64'h508 || pc64 !== 64'h500) begin miscompares++; $display("FAIL rstmid_resume actual=v%b i%h t%h pc%h expected=v1 i8 t508 pc500", out_valid64, imm64, target64, pc64); end
        vectors++; if (out_valid32 !== 1'b1 || target32 !== 32'h508) begin miscompares++; $display("FAIL rstmid_resume32 actual=v%b t%h expected=v1 t508", out_valid32, target32); end
        tick();
        vectors++; if (out_valid64 !== 1'b0) begin miscompares++; $display("FAIL rstmid_drain actual=v%b expected=v0", out_valid64); end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        inst_i      = 32'h0;
        imm_sel_i   = 3'd0;
        pc_i        = 64'h0;
        out_ready_i = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
